// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the register_file_2r1w block.
//   clr_state_t : clear-engine state (IDLE, CLEAR)
//   addr_w()    : address width for a given word count
//   zero_word() : all-zero word of MAX_WIDTH bits; users slice it to WIDTH
// Optional feature macro used by the block: REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Widest word the zero_word() helper can supply.
    localparam int MAX_WIDTH = 1024;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] zero_word();
        return '0;
    endfunction

endpackage

// File: rtl/register_file_2r1w_if.sv
// -----------------------------------------------------------------------------
// register_file_2r1w_if
// Bus bundle for the register file.
//   we/wr_addr/wr_data     : write port (sampled on rising clk)
//   rd_addr_a/rd_data_a    : combinational read port A
//   rd_addr_b/rd_data_b    : combinational read port B
//   clr                    : request a sequenced clear
//   busy                   : clear sweep in progress
//   wr_err                 : sticky dropped-write flag
//   state                  : clear-engine state, for observation
// Handshake: no valid/ready pair. A write is taken on the rising edge when
// we=1 and the block is IDLE with clr=0; any other write with we=1 is dropped
// and raises wr_err. clr is taken only in IDLE; busy=1 means clr and writes
// are not accepted.
// master = the client (decode/write-back), slave = the register file.
// -----------------------------------------------------------------------------
interface register_file_2r1w_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int AW = addr_w(DEPTH);

    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             clr;
    logic             busy;
    logic             wr_err;
    clr_state_t       state;

    modport master (
        output we, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr,
        input  rd_data_a, rd_data_b, busy, wr_err, state
    );

    modport slave (
        input  we, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr,
        output rd_data_a, rd_data_b, busy, wr_err, state
    );
endinterface

// File: rtl/regfile_clear_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clear_fsm
// Clear-sweep sequencer and write qualifier for the register file.
//   i_clr        : clear request (taken only in IDLE)
//   i_we         : write enable from the client
//   o_state      : current state
//   o_idx        : sweep index (entry zeroed on the next edge while busy)
//   o_busy       : sweep in progress
//   o_wr_accept  : the write presented this cycle will be stored
//   o_wr_err     : sticky flag, a write was dropped
// -----------------------------------------------------------------------------
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_we,
    output clr_state_t    o_state,
    output logic [AW-1:0] o_idx,
    output logic          o_busy,
    output logic          o_wr_accept,
    output logic          o_wr_err
);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW-1:0] r_idx;
    logic          r_wr_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_clr) w_state_nxt = CLEAR;
            CLEAR:   if (r_idx == LAST_IDX) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // DEPTH is a power of two, so the index wraps to 0 on the last
            // sweep edge and is ready for the next clear.
            if (r_state == CLEAR) r_idx <= r_idx + AW'(1);
            else                  r_idx <= '0;
            // Accepting clr clears the flag, but a write dropped in that same
            // cycle must still be reported, so it wins.
            if (r_state == IDLE && i_clr)       r_wr_err <= i_we;
            else if (r_state == CLEAR && i_we)  r_wr_err <= 1'b1;
        end
    end

    assign o_state     = r_state;
    assign o_idx       = r_idx;
    assign o_busy      = (r_state == CLEAR);
    assign o_wr_accept = i_we && (r_state == IDLE) && !i_clr;
    assign o_wr_err    = r_wr_err;

endmodule

// File: rtl/register_file_2r1w.sv
// -----------------------------------------------------------------------------
// register_file_2r1w
// DEPTH x WIDTH architectural register bank: one synchronous write port, two
// combinational read ports, optional hard-wired zero entry, sequenced clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : register_file_2r1w_if.slave (write, read A/B, clr, busy,
//                wr_err, state)
// Parameters: WIDTH, DEPTH (power of two), ZERO_REG (1: entry 0 reads 0).
// Build option: REGFILE_BYPASS_EN forwards an accepted same-cycle write to a
// matching read port.
// -----------------------------------------------------------------------------
module register_file_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ZERO_REG = 1
) (
    input logic clk,
    input logic rst_n,
    register_file_2r1w_if.slave bus
);
    localparam int AW = addr_w(DEPTH);
    localparam logic [MAX_WIDTH-1:0] ZERO_FULL = zero_word();
    localparam logic [WIDTH-1:0]     ZERO_W    = ZERO_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    clr_state_t       w_state;
    logic [AW-1:0]    w_idx;
    logic             w_busy;
    logic             w_wr_accept;
    logic             w_wr_err;
    logic             w_wr_zero;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    regfile_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (bus.clr),
        .i_we        (bus.we),
        .o_state     (w_state),
        .o_idx       (w_idx),
        .o_busy      (w_busy),
        .o_wr_accept (w_wr_accept),
        .o_wr_err    (w_wr_err)
    );

    // Writes to the hard-wired zero entry are accepted but have no effect.
    assign w_wr_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= ZERO_W;
        end else if (w_busy) begin
            r_mem[w_idx] <= ZERO_W;
        end else if (w_wr_accept && !w_wr_zero) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        w_rd_a = r_mem[bus.rd_addr_a];
        w_rd_b = r_mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        // Only accepted writes are forwarded; dropped ones never reach storage.
        if (w_wr_accept && bus.wr_addr == bus.rd_addr_a) w_rd_a = bus.wr_data;
        if (w_wr_accept && bus.wr_addr == bus.rd_addr_b) w_rd_b = bus.wr_data;
`endif
        // Zero-entry masking is applied last so forwarding cannot override it.
        if (ZERO_REG != 0 && bus.rd_addr_a == '0) w_rd_a = ZERO_W;
        if (ZERO_REG != 0 && bus.rd_addr_b == '0) w_rd_b = ZERO_W;
    end

    assign bus.rd_data_a = w_rd_a;
    assign bus.rd_data_b = w_rd_b;
    assign bus.busy      = w_busy;
    assign bus.wr_err    = w_wr_err;
    assign bus.state     = w_state;

endmodule

// File: tb/tb_register_file_2r1w.sv
// -----------------------------------------------------------------------------
// tb_register_file_2r1w
// Self-checking bench for register_file_2r1w (WIDTH=32, DEPTH=32, ZERO_REG=1).
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_register_file_2r1w;
    import regfile_pkg::*;

    localparam int W = 32;
    localparam int D = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_file_2r1w_if #(.WIDTH(W), .DEPTH(D)) bus ();

    register_file_2r1w #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mdl [D];

    typedef struct {
        logic         we;
        logic [4:0]   wa;
        logic [W-1:0] wd;
        logic [4:0]   ra;
        logic [4:0]   rb;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_rd(input logic [W-1:0] ea, input logic [W-1:0] eb);
        exp_q.push_back(ea);
        exp_q.push_back(eb);
    endtask

    task automatic pop_rd(input string nm);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        if (exp_q.size() < 2) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard_empty actual=%0d required=2", nm, exp_q.size());
        end else begin
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            chk({nm, "_a"}, bus.rd_data_a, ea);
            chk({nm, "_b"}, bus.rd_data_b, eb);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // a further unit later, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string nm, input logic [4:0] ra, input logic [4:0] rb,
                              input logic [W-1:0] ea, input logic [W-1:0] eb);
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        push_rd(ea, eb);
        #1;
        pop_rd(nm);
    endtask

    task automatic do_write(input logic [4:0] wa, input logic [W-1:0] wd);
        bus.we      = 1'b1;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.busy) begin
            failures++;
            $display("FAIL %s busy_timeout actual=1 required=0", nm);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < D; i++) mdl[i] = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           k;
        logic [W-1:0] exp_byp;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31, 32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0};
        vecs[3] = '{1'b1, 5'd7,  32'h11112222, 5'd7, 5'd7,  32'h11112222, 32'h11112222};
        vecs[4] = '{1'b1, 5'd5,  32'h0BADF00D, 5'd5, 5'd31, 32'h0BADF00D, 32'h12345678};
        vecs[5] = '{1'b0, 5'd9,  32'h99999999, 5'd9, 5'd5,  32'h0,        32'h0BADF00D};

        bus.we        = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.clr       = 1'b0;
        clear_model();

        // Reset state, including reads while reset is held.
        #2;
        chk("rst_busy", W'(bus.busy), '0);
        chk("rst_wr_err", W'(bus.wr_err), '0);
        chk("rst_state", W'(bus.state), W'(IDLE));
        read_check("rst_hold_rd", 5'd5, 5'd31, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) read_check("rst_rd", 5'(i), 5'(D - 1 - i), '0, '0);

        // Table of write-then-read vectors.
        for (int v = 0; v < 6; v++) begin
            bus.we      = vecs[v].we;
            bus.wr_addr = vecs[v].wa;
            bus.wr_data = vecs[v].wd;
            tick();
            bus.we = 1'b0;
            if (vecs[v].we && vecs[v].wa != 5'd0) mdl[vecs[v].wa] = vecs[v].wd;
            read_check($sformatf("vec%0d", v), vecs[v].ra, vecs[v].rb, vecs[v].ea, vecs[v].eb);
        end
        chk("zero_write_no_err", W'(bus.wr_err), '0);

        // Same-cycle write and read of address 7.
        bus.we      = 1'b1;
        bus.wr_addr = 5'd7;
        bus.wr_data = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hA5A5A5A5;
`else
        exp_byp = mdl[7];
`endif
        read_check("same_cycle", 5'd7, 5'd0, exp_byp, '0);
        tick();
        bus.we = 1'b0;
        mdl[7] = 32'hA5A5A5A5;
        read_check("after_edge", 5'd7, 5'd0, 32'hA5A5A5A5, '0);

        // Same-cycle write to the zero entry is never visible.
        bus.we      = 1'b1;
        bus.wr_addr = 5'd0;
        bus.wr_data = 32'hFFFFFFFF;
        read_check("zero_same_cycle", 5'd0, 5'd0, '0, '0);
        tick();
        bus.we = 1'b0;
        read_check("zero_after", 5'd0, 5'd0, '0, '0);
        chk("zero_err", W'(bus.wr_err), '0);

        // Fill 1..31 with nonzero data, then sweep.
        for (int a = 1; a < D; a++) begin
            mdl[a] = $urandom() | 32'h1;
            do_write(5'(a), mdl[a]);
        end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        k = 0;
        while (bus.busy && k < 100) begin
            // Repeated clr mid-sweep must not restart it; a write must be dropped.
            bus.clr = (k == 3 || k == 4);
            if (k == 10) begin
                bus.we      = 1'b1;
                bus.wr_addr = 5'd3;
                bus.wr_data = 32'h55;
            end else begin
                bus.we = 1'b0;
            end
            if (k < D)
                read_check($sformatf("sweep_k%0d", k), 5'((k > 0) ? k - 1 : 0), 5'(k),
                           '0, (k == 0) ? '0 : mdl[k]);
            tick();
            k++;
        end
        bus.clr = 1'b0;
        bus.we  = 1'b0;
        chk("busy_cycles", W'(k), W'(D));
        clear_model();
        chk("sweep_drop_err", W'(bus.wr_err), 32'h1);
        for (int i = 0; i < D; i++) read_check("post_sweep", 5'(i), 5'((i + 16) % D), '0, '0);

        // clr without write clears the sticky flag.
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr_clears_err", W'(bus.wr_err), '0);
        chk("clr_busy", W'(bus.busy), 32'h1);
        wait_idle("sweep2");

        // Write together with clr in IDLE is dropped.
        bus.we      = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 32'h55;
        bus.clr     = 1'b1;
        tick();
        bus.we  = 1'b0;
        bus.clr = 1'b0;
        chk("drop_with_clr_err", W'(bus.wr_err), 32'h1);
        chk("drop_with_clr_busy", W'(bus.busy), 32'h1);
        wait_idle("sweep3");

        // First cycle with busy=0 accepts a write.
        bus.we      = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 32'h77;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h77;
`else
        exp_byp = '0;
`endif
        read_check("first_idle_wr", 5'd3, 5'd4, exp_byp, '0);
        tick();
        bus.we = 1'b0;
        read_check("first_idle_rd", 5'd3, 5'd4, 32'h77, '0);
        chk("err_still_set", W'(bus.wr_err), 32'h1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("next_clr_clears", W'(bus.wr_err), '0);
        wait_idle("sweep4");
        clear_model();

        // Reset in the middle of a sweep.
        for (int a = 1; a < D; a++) begin
            mdl[a] = $urandom() | 32'h1;
            do_write(5'(a), mdl[a]);
        end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_busy_before_rst", W'(bus.busy), 32'h1);
        read_check("mid_unswept", 5'd20, 5'd9, mdl[20], '0);
        rst_n = 1'b0;
        #1;
        clear_model();
        chk("mid_rst_busy", W'(bus.busy), '0);
        chk("mid_rst_state", W'(bus.state), W'(IDLE));
        read_check("mid_rst_rd1", 5'd20, 5'd31, '0, '0);
        read_check("mid_rst_rd2", 5'd15, 5'd25, '0, '0);
        tick();
        rst_n = 1'b1;
        do_write(5'd20, 32'hCAFE0020);
        read_check("post_rst_wr", 5'd20, 5'd21, 32'hCAFE0020, '0);
        chk("post_rst_err", W'(bus.wr_err), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the bench must always end by itself.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
